// File: rtl/reg_file_sb_if.sv
// reg_file_sb_if: groups the decode-side and writeback-side signals of the
// register file. The master side is decode/writeback; the slave side is the file.
interface reg_file_sb_if #(
    parameter int WORD_W = 32,
    parameter int ADDR_B = 5,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2,
    parameter int CNT_B  = 6
);
    logic [NUM_RD*ADDR_B-1:0] i_read_addr;
    logic [NUM_RD*WORD_W-1:0] o_read_data;
    logic [NUM_RD-1:0]        o_read_busy;
    logic [NUM_WR-1:0]        i_wen;
    logic [NUM_WR*ADDR_B-1:0] i_write_addr;
    logic [NUM_WR*WORD_W-1:0] i_write_data;
    logic                     i_rsv_en;
    logic [ADDR_B-1:0]        i_rsv_addr;
    logic                     i_flush;
    logic [CNT_B-1:0]         o_busy_cnt;

    modport master (
        output i_read_addr, i_wen, i_write_addr, i_write_data,
               i_rsv_en, i_rsv_addr, i_flush,
        input  o_read_data, o_read_busy, o_busy_cnt
    );

    modport slave (
        input  i_read_addr, i_wen, i_write_addr, i_write_data,
               i_rsv_en, i_rsv_addr, i_flush,
        output o_read_data, o_read_busy, o_busy_cnt
    );
endinterface

// File: rtl/reg_file_sb.sv
// reg_file_sb: multi-port register file with write-to-read bypass and a
// per-register busy scoreboard plus a registered busy population count.
// Optional: define REG_FILE_SB_ZERO_REG_EN to hardwire register 0 to zero
// (never written, never busy, bypass to it also reads zero).

// One read port: stored value/busy, overridden by a same-cycle write (highest
// write port wins), zero for out-of-range addresses or while in reset.
module reg_file_sb_rd #(
    parameter int WORD_W = 32,
    parameter int WORD_D = 32,
    parameter int ADDR_B = 5,
    parameter int NUM_WR = 2
) (
    input  logic                           rst_n,
    input  logic [ADDR_B-1:0]              addr,
    input  logic [WORD_D-1:0][WORD_W-1:0]  mem,
    input  logic [WORD_D-1:0]              busy,
    input  logic [NUM_WR-1:0]              wen,
    input  logic [NUM_WR-1:0][ADDR_B-1:0]  waddr,
    input  logic [NUM_WR-1:0][WORD_W-1:0]  wdata,
    output logic [WORD_W-1:0]              data,
    output logic                           hit_busy
);
    logic in_range;

    // Stored lookup, then bypass; later write ports override earlier ones.
    always_comb begin
        data     = '0;
        hit_busy = 1'b0;
        in_range = 1'b0;
        for (int r = 0; r < WORD_D; r++) begin
            if (addr == ADDR_B'(r)) begin
                in_range = 1'b1;
                data     = mem[r];
                hit_busy = busy[r];
            end
        end
        if (in_range) begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (wen[w] && waddr[w] == addr) begin
                    data     = wdata[w];
                    hit_busy = 1'b0;
                end
            end
        end
`ifdef REG_FILE_SB_ZERO_REG_EN
        if (addr == '0) begin
            data     = '0;
            hit_busy = 1'b0;
        end
`endif
        if (!rst_n) begin
            data     = '0;
            hit_busy = 1'b0;
        end
    end
endmodule

module reg_file_sb #(
    parameter int WORD_W = 32,
    parameter int WORD_D = 32,
    parameter int ADDR_B = 5,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2,
    parameter int CNT_B  = 6
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    reg_file_sb_if.slave bus
);
    logic [WORD_D-1:0][WORD_W-1:0] mem, mem_nxt;
    logic [WORD_D-1:0]             busy, busy_nxt, wr_hit;
    logic [CNT_B-1:0]              busy_cnt, cnt_nxt;
    logic [NUM_WR-1:0][ADDR_B-1:0] waddr;
    logic [NUM_WR-1:0][WORD_W-1:0] wdata;
    logic [NUM_RD-1:0][ADDR_B-1:0] raddr;
    logic [NUM_RD-1:0][WORD_W-1:0] rdata;
    logic [NUM_RD-1:0]             rbusy;

    assign waddr = bus.i_write_addr;
    assign wdata = bus.i_write_data;
    assign raddr = bus.i_read_addr;

    // Next register contents: ascending port order so the highest enabled port wins.
    always_comb begin
        mem_nxt = mem;
        wr_hit  = '0;
        for (int r = 0; r < WORD_D; r++) begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (bus.i_wen[w] && waddr[w] == ADDR_B'(r)) begin
                    mem_nxt[r] = wdata[w];
                    wr_hit[r]  = 1'b1;
                end
            end
        end
`ifdef REG_FILE_SB_ZERO_REG_EN
        mem_nxt[0] = '0;
`endif
    end

    // Scoreboard: flush > reservation > writeback clear > hold.
    always_comb begin
        busy_nxt = busy;
        cnt_nxt  = '0;
        for (int r = 0; r < WORD_D; r++) begin
            if (wr_hit[r])
                busy_nxt[r] = 1'b0;
            if (bus.i_rsv_en && bus.i_rsv_addr == ADDR_B'(r))
                busy_nxt[r] = 1'b1;
            if (bus.i_flush)
                busy_nxt[r] = 1'b0;
        end
`ifdef REG_FILE_SB_ZERO_REG_EN
        busy_nxt[0] = 1'b0;
`endif
        for (int r = 0; r < WORD_D; r++)
            cnt_nxt = cnt_nxt + CNT_B'(busy_nxt[r]);
    end

    // State update; reset clears data, busy bits and count at once.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mem      <= '0;
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            mem      <= mem_nxt;
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        reg_file_sb_rd #(
            .WORD_W(WORD_W), .WORD_D(WORD_D), .ADDR_B(ADDR_B), .NUM_WR(NUM_WR)
        ) u_rd (
            .rst_n    (i_rst_n),
            .addr     (raddr[k]),
            .mem      (mem),
            .busy     (busy),
            .wen      (bus.i_wen),
            .waddr    (waddr),
            .wdata    (wdata),
            .data     (rdata[k]),
            .hit_busy (rbusy[k])
        );
    end

    assign bus.o_read_data = rdata;
    assign bus.o_read_busy = rbusy;
    assign bus.o_busy_cnt  = busy_cnt;
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed checks of reg_file_sb (WORD_D=24 so out-of-range
// addresses are reachable with 5 address bits).
module tb_reg_file_sb;
    localparam int WORD_W = 32;
    localparam int WORD_D = 24;
    localparam int ADDR_B = 5;
    localparam int NUM_RD = 2;
    localparam int NUM_WR = 2;
    localparam int CNT_B  = 6;
`ifdef REG_FILE_SB_ZERO_REG_EN
    localparam bit ZR = 1'b1;
`else
    localparam bit ZR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    reg_file_sb_if #(
        .WORD_W(WORD_W), .ADDR_B(ADDR_B), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR), .CNT_B(CNT_B)
    ) bus ();

    reg_file_sb #(
        .WORD_W(WORD_W), .WORD_D(WORD_D), .ADDR_B(ADDR_B),
        .NUM_RD(NUM_RD), .NUM_WR(NUM_WR), .CNT_B(CNT_B)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.i_wen      = '0;
        bus.i_rsv_en   = 1'b0;
        bus.i_flush    = 1'b0;
    endtask

    task automatic rd(input int k, input int a);
        bus.i_read_addr[k*ADDR_B +: ADDR_B] = ADDR_B'(a);
    endtask

    task automatic wr(input int w, input int a, input logic [31:0] d);
        bus.i_wen[w] = 1'b1;
        bus.i_write_addr[w*ADDR_B +: ADDR_B] = ADDR_B'(a);
        bus.i_write_data[w*WORD_W +: WORD_W] = d;
    endtask

    task automatic rsv(input int a);
        bus.i_rsv_en   = 1'b1;
        bus.i_rsv_addr = ADDR_B'(a);
    endtask

    function automatic logic [31:0] rdat(input int k);
        return bus.o_read_data[k*WORD_W +: WORD_W];
    endfunction

    function automatic logic [31:0] rbsy(input int k);
        return 32'(bus.o_read_busy[k]);
    endfunction

    function automatic logic [31:0] cnt();
        return 32'(bus.o_busy_cnt);
    endfunction

    initial begin
        bus.i_read_addr  = '0;
        bus.i_write_addr = '0;
        bus.i_write_data = '0;
        bus.i_rsv_addr   = '0;
        idle();

        // reads under reset are zero even with a write pending
        wr(0, 5, 32'hDEAD_BEEF);
        rd(1, 5);
        #2;
        chk("rst_rd_data", rdat(1), 32'h0);
        chk("rst_rd_busy", rbsy(1), 32'h0);
        chk("rst_cnt", cnt(), 32'h0);
        idle();
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk("post_rst_r5", rdat(1), 32'h0);

        // write r5 then read it on port1
        wr(0, 5, 32'hDEAD_BEEF);
        tick();
        idle();
        rd(1, 5);
        rd(0, 6);
        #1;
        chk("wr_r5_data", rdat(1), 32'hDEAD_BEEF);
        chk("wr_r5_busy", rbsy(1), 32'h0);
        chk("wr_r6_zero", rdat(0), 32'h0);
        rd(0, 0);  #1; chk("r0_zero", rdat(0), 32'h0);
        rd(0, 23); #1; chk("r23_zero", rdat(0), 32'h0);

        // same-address conflict: port1 wins, visible by bypass then stored
        wr(0, 7, 32'h1111_1111);
        wr(1, 7, 32'h2222_2222);
        rd(0, 7);
        #1;
        chk("byp_r7_data", rdat(0), 32'h2222_2222);
        chk("byp_r7_busy", rbsy(0), 32'h0);
        tick();
        idle();
        #1;
        chk("st_r7_data", rdat(0), 32'h2222_2222);

        // two ports, distinct addresses
        wr(0, 10, 32'h0000_00AA);
        wr(1, 11, 32'h0000_00BB);
        tick();
        idle();
        rd(0, 10);
        rd(1, 11);
        #1;
        chk("st_r10", rdat(0), 32'h0000_00AA);
        chk("st_r11", rdat(1), 32'h0000_00BB);

        // reserve r3
        rsv(3);
        tick();
        idle();
        rd(0, 3);
        #1;
        chk("rsv_r3_busy", rbsy(0), 32'h1);
        chk("rsv_r3_cnt", cnt(), 32'h1);

        // writeback r3: bypassed read is not busy, busy clears after edge
        wr(0, 3, 32'h5);
        #1;
        chk("wb_r3_byp_data", rdat(0), 32'h5);
        chk("wb_r3_byp_busy", rbsy(0), 32'h0);
        tick();
        idle();
        #1;
        chk("wb_r3_busy", rbsy(0), 32'h0);
        chk("wb_r3_cnt", cnt(), 32'h0);
        chk("wb_r3_data", rdat(0), 32'h5);

        // reserve r3 twice in a row: no double count
        rsv(3);
        tick();
        tick();
        idle();
        #1;
        chk("rsv2_r3_cnt", cnt(), 32'h1);
        chk("rsv2_r3_busy", rbsy(0), 32'h1);

        // reservation beats same-cycle writeback of r9
        rsv(9);
        wr(1, 9, 32'hA5A5_A5A5);
        tick();
        idle();
        rd(0, 9);
        #1;
        chk("rsv_wb_r9_busy", rbsy(0), 32'h1);
        chk("rsv_wb_r9_data", rdat(0), 32'hA5A5_A5A5);
        chk("rsv_wb_cnt", cnt(), 32'h2);

        // clear r3 and r9 with writebacks
        wr(0, 3, 32'h33);
        wr(1, 9, 32'h99);
        tick();
        idle();
        #1;
        chk("clr_cnt", cnt(), 32'h0);

        // out-of-range write/read/reserve are ignored
        wr(0, 30, 32'hCAFE_F00D);
        rsv(30);
        rd(0, 30);
        #1;
        chk("oor_byp_data", rdat(0), 32'h0);
        chk("oor_byp_busy", rbsy(0), 32'h0);
        tick();
        idle();
        #1;
        chk("oor_cnt", cnt(), 32'h0);
        chk("oor_data", rdat(0), 32'h0);

        // build up three reservations, then flush with a competing reserve
        rsv(1); tick();
        rsv(2); tick();
        rsv(4); tick();
        idle();
        rd(0, 2);
        #1;
        chk("fl_pre_cnt", cnt(), 32'h3);
        chk("fl_pre_r2_busy", rbsy(0), 32'h1);
        bus.i_flush = 1'b1;
        rsv(6);
        tick();
        idle();
        rd(0, 6);
        rd(1, 4);
        #1;
        chk("fl_cnt", cnt(), 32'h0);
        chk("fl_r6_busy", rbsy(0), 32'h0);
        chk("fl_r4_busy", rbsy(1), 32'h0);
        rd(0, 5);
        rd(1, 7);
        #1;
        chk("fl_r5_data", rdat(0), 32'hDEAD_BEEF);
        chk("fl_r7_data", rdat(1), 32'h2222_2222);

        // register 0 behaviour depends on the zero-register option
        wr(0, 0, 32'hFFFF_FFFF);
        rd(0, 0);
        #1;
        chk("r0_byp_data", rdat(0), ZR ? 32'h0 : 32'hFFFF_FFFF);
        tick();
        idle();
        rsv(0);
        tick();
        idle();
        #1;
        chk("r0_rsv_cnt", cnt(), ZR ? 32'h0 : 32'h1);
        chk("r0_rsv_busy", rbsy(0), ZR ? 32'h0 : 32'h1);

        // asynchronous reset mid-cycle drops a pending write
        wr(0, 5, 32'h0000_0123);
        rd(1, 5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_cnt", cnt(), 32'h0);
        chk("mid_rst_rd", rdat(1), 32'h0);
        idle();
        tick();
        rst_n = 1'b1;
        #1;
        chk("mid_rst_r5", rdat(1), 32'h0);
        chk("mid_rst_r0_busy", rbsy(0), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Next-generation register file with a configurable number of read ports (NUM_RD) and write ports (NUM_WR).
- Adds write-to-read bypass and a per-register busy scoreboard that tracks in-flight writebacks.
- Sits between decode (reads, reservations) and the writeback stages (ALU and load return).
- Decode uses the busy flags and o_busy_cnt to stall dependent instructions.

Parameters:
- WORD_W, 32, bits per register
- WORD_D, 32, number of registers
- ADDR_B, 5, address bits; 2^ADDR_B >= WORD_D
- NUM_RD, 2, read ports
- NUM_WR, 2, write ports; higher index has higher priority
- CNT_B, 6, width of o_busy_cnt; 2^CNT_B > WORD_D

Ports:
- i_clk  input  1  clock, rising edge
- i_rst_n  input  1  asynchronous active-low reset
- i_read_addr  input  NUM_RD*ADDR_B  read addresses; port k uses slice [k*ADDR_B +: ADDR_B]
- o_read_data  output  NUM_RD*WORD_W  read data, combinational
- o_read_busy  output  NUM_RD  busy flag of each addressed register, after bypass
- i_wen  input  NUM_WR  write enables
- i_write_addr  input  NUM_WR*ADDR_B  write addresses
- i_write_data  input  NUM_WR*WORD_W  write data
- i_rsv_en  input  1  reserve a destination register (set its busy bit)
- i_rsv_addr  input  ADDR_B  register to reserve
- i_flush  input  1  synchronous clear of all busy bits; data is kept
- o_busy_cnt  output  CNT_B  number of registers currently busy, registered

Behaviour:
- Reset (asynchronous, i_rst_n=0):
  - all registers = 0, all busy bits = 0, o_busy_cnt = 0.
  - Reads during reset return 0 with busy 0.
- Write:
  - On each rising edge, every port w with i_wen[w]=1 and address < WORD_D writes its data.
  - Same-address conflict: the highest-index enabled port wins; lower ports' data are dropped.
  - Writes to address >= WORD_D are ignored and have no effect on busy.
- Read (combinational, zero latency):
  - If the address matches an enabled write port this cycle, return that port's data (highest index wins) and busy = 0.
  - Otherwise return the stored register and its busy bit.
  - Address >= WORD_D returns 0, busy 0.
- Scoreboard, next busy per register r:
  - i_flush=1: 0 for all r. Overrides everything, including the same-cycle i_rsv_en.
  - else if i_rsv_en and i_rsv_addr==r: 1. A reservation beats a same-cycle writeback clear, so the new owner keeps the register.
  - else if any enabled write port targets r: 0.
  - else: unchanged.
  - Reserving an already-busy register leaves it busy. Count is not double-incremented.
  - Reserving address >= WORD_D is ignored.
- o_busy_cnt:
  - Registered population count of the busy vector.
  - Updates on the same edge as the busy bits, so it reflects next-state busy one cycle after the causing event.
  - Never exceeds WORD_D.
- Mid-operation reset: asynchronous; takes effect immediately, with no pending writes retained.

Optional Feature:
- Macro: REG_FILE_SB_ZERO_REG_EN.
- When defined:
  - register 0 is hardwired to 0; writes to it are discarded;
  - it can never be reserved (busy stays 0, not counted);
  - reads of address 0 return 0 even when bypassing a same-cycle write to 0.
- When undefined: register 0 behaves as any other register.

Test Plan:
- Reset then write: reset; write 0xDEADBEEF to r5 on port0; next cycle read r5 on port1 -> 0xDEADBEEF, busy 0. All other addresses read 0.
- Bypass and priority: same cycle, port0 writes 0x11111111 and port1 writes 0x22222222 to r7, read r7 -> 0x22222222 combinationally. After the edge the stored value is 0x22222222.
- Scoreboard:
  - reserve r3 -> o_read_busy=1 for r3 and o_busy_cnt=1 next cycle;
  - write r3=0x5 -> the same-cycle read returns 0x5 with busy 0; busy and count are 0 after the edge;
  - reserve r3 again while it is busy -> count stays 1.
- Reserve vs writeback: reserve r9 while port1 writes r9 -> r9 busy=1 after the edge, data = new write value.
- Flush:
  - reserve r1, r2, r4 on successive cycles -> count reaches 3;
  - i_flush=1 together with i_rsv_en on r6 -> all busy 0, count 0, register data unchanged.
- With REG_FILE_SB_ZERO_REG_EN: write 0xFFFFFFFF to r0 and read r0 in the same cycle -> 0; reserve r0 -> busy 0, count 0. Without the macro, the same stimulus -> 0xFFFFFFFF, count 1.
